multi_nbit_unsigned_seq: RTL

//  Parametrised unsigned WIDTH x WIDTH multiplier built from four HALF-width sequential shift-add
//  sub-multipliers (aH*bL, aL*bL, aH*bH, aL*bH). Partial products are merged by a one-level CSA plus a

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_half_seq.sv | 56 +++++
 rtl/multi_nbit_unsigned_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the split-operand sequential multiplier.
// State encoding for the top-level controller plus a width helper for counters.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      MERGE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mult_half_seq.sv
// HALF x HALF unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high during the cycle whose closing edge performs the last iteration.
module mult_half_seq
   import mult_pkg::*;
#(
   parameter int HALF = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [HALF-1:0]   a,
   input  logic [HALF-1:0]   b,
   output logic [2*HALF-1:0] prod,
   output logic              done
);

   localparam int CW = clog2(HALF);

   logic [2*HALF-1:0] mcand_reg;
   logic [2*HALF-1:0] acc_reg;
   logic [HALF-1:0]   mplier_reg;
   logic [CW-1:0]     cnt_reg;
   logic              running_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_reg   <= '0;
         acc_reg     <= '0;
         mplier_reg  <= '0;
         cnt_reg     <= '0;
         running_reg <= 1'b0;
      end else if (start) begin
         mcand_reg   <= {{HALF{1'b0}}, a};
         mplier_reg  <= b;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         running_reg <= 1'b1;
      end else if (running_reg) begin
         if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
         end
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         if (cnt_reg == CW'(HALF - 1)) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign done = running_reg && (cnt_reg == CW'(HALF - 1));
   assign prod = acc_reg;

endmodule

// File: rtl/multi_nbit_unsigned_seq.sv
// WIDTH x WIDTH unsigned multiplier from four half-width sequential multipliers, CSA + CPA merge.
// Optional MULT_FASTPATH_EN: trivial operands (0 or 1) bypass the sub-multipliers.
module multi_nbit_unsigned_seq #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               busy
);
   import mult_pkg::*;

   localparam int HALF = WIDTH / 2;

   state_t             state_reg;
   state_t             state_next;
   logic               accept;
   logic               fast_hit;
   logic               start;
   logic [2*WIDTH-1:0] fast_prod;
   logic [2*WIDTH-1:0] merge_prod;
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH-1:0]   pp [4];
   logic [3:0]         done_vec;
   logic [WIDTH-1:0]   csa_x;
   logic [WIDTH-1:0]   csa_y;
   logic [WIDTH-1:0]   csa_z;
   logic [WIDTH-1:0]   csa_s;
   logic [WIDTH-1:0]   csa_c;
   logic [3*HALF-1:0]  upper_sum;

   assign accept = in_valid && in_ready;
   assign start  = accept && !fast_hit;

`ifdef MULT_FASTPATH_EN
   always_comb begin
      fast_hit  = 1'b1;
      fast_prod = '0;
      if ((a == '0) || (b == '0)) begin
         fast_prod = '0;
      end else if (a == WIDTH'(1)) begin
         fast_prod = {{WIDTH{1'b0}}, b};
      end else if (b == WIDTH'(1)) begin
         fast_prod = {{WIDTH{1'b0}}, a};
      end else begin
         fast_hit = 1'b0;
      end
   end
`else
   assign fast_hit  = 1'b0;
   assign fast_prod = '0;
`endif

   // Instance order: aH*bL, aL*bL, aH*bH, aL*bH
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_half
         localparam bit A_HI = (gi == 0) || (gi == 2);
         localparam bit B_HI = (gi >= 2);
         logic [HALF-1:0] op_a;
         logic [HALF-1:0] op_b;
         assign op_a = A_HI ? a[WIDTH-1:HALF] : a[HALF-1:0];
         assign op_b = B_HI ? b[WIDTH-1:HALF] : b[HALF-1:0];
         mult_half_seq #(.HALF(HALF)) u_half (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .a     (op_a),
            .b     (op_b),
            .prod  (pp[gi]),
            .done  (done_vec[gi])
         );
      end
   endgenerate

   lockstep_check: assert property (@(posedge clk) disable iff (rst)
      done_vec == {4{done_vec[0]}});

   // Product bits above HALF: aH*bL + aL*bH + aH*bH<<HALF + aL*bL>>HALF, carry-out dropped
   always_comb begin
      csa_x      = pp[0];
      csa_y      = {pp[2][HALF-1:0], pp[1][WIDTH-1:HALF]};
      csa_z      = pp[3];
      csa_s      = csa_x ^ csa_y ^ csa_z;
      csa_c      = (csa_x & csa_y) | (csa_x & csa_z) | (csa_y & csa_z);
      upper_sum  = {pp[2][WIDTH-1:HALF], csa_s} + {{(HALF-1){1'b0}}, csa_c, 1'b0};
      merge_prod = {upper_sum, pp[1][HALF-1:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = fast_hit ? DONE : RUN;
         RUN:     if (done_vec[0]) state_next = MERGE;
         MERGE:   state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      busy      = (state_reg != IDLE);
      out_valid = (state_reg == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_reg <= '0;
      end else if ((state_reg == IDLE) && accept && fast_hit) begin
         prod_reg <= fast_prod;
      end else if (state_reg == MERGE) begin
         prod_reg <= merge_prod;
      end
   end

   assign prod = prod_reg;

endmodule
